cache_port_arbiter: RTL
=======================

# cache_port_arbiter

Two-port arbiter that shares the single write-through data cache between the instruction-fetch requester (port 0) and the load/store requester (port 1). It sequences one cache transaction at a time, holds the granted request stable on the cache inputs until the cache signals completion via Stall, and returns read data with a one-cycle acknowledge. It also keeps saturating hit/stall statistics counters for performance bring-up.

## Interface
- ADDR_W, 10, word-address width (matches cache WordAddress)
- DATA_W, 32, data width
- CNT_W, 16, width of the statistics counters
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- p0_rd, p1_rd  in  1 each  read request; level, held until ack
- p0_wr, p1_wr  in  1 each  write request; level, held until ack
- p0_addr, p1_addr  in  ADDR_W each  word address
- p0_wdata, p1_wdata  in  DATA_W each  write data
- p0_ack, p1_ack  out  1 each  one-cycle completion pulse
- p0_rdata, p1_rdata  out  DATA_W each  registered read data, valid from ack cycle, held until next read on that port
- MemRead, MemWrite  out  1 each  cache request strobes
- WordAddress  out  ADDR_W  cache address
- DataIn  out  DATA_W  cache write data
- DataOut  in  DATA_W  cache read data
- Stall  in  1  cache busy (miss fill or write-through in progress)
- hit_cnt, stall_cnt  out  CNT_W each  completed transactions without / with Stall seen

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: cache strobes low. A port requests when rd or wr is high. One requester → grant it. Both → round-robin: grant the port not granted last. Transition to ISSUE on a grant.
- Both rd and wr high on one port: write takes precedence; rd ignored for that transaction.
- ISSUE: drive MemRead/MemWrite, WordAddress, DataIn from the latched owner (requests captured into internal registers at grant; requester inputs not re-sampled). Cache contract: Stall rises combinationally in the same cycle as a miss or write is presented. Stall low at the edge → hit: capture DataOut (reads), hit_cnt+1, go RESP. Stall high → WAIT.
- WAIT: keep driving same request. On the first edge with Stall low: capture DataOut (reads), stall_cnt+1, go RESP.
- RESP: strobes low (one bubble cycle so the cache sees a fresh request edge); owner ack = 1; last-granted pointer = owner; requests not sampled; go IDLE.
- Writes do not update pN_rdata.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, all outputs 0 (strobes, WordAddress, DataIn, acks, rdata, counters); last-granted pointer = port 1, so port 0 wins first contention.
- Reset mid-transaction: transaction abandoned, no ack, cache strobes drop immediately.
- Hit latency: request high in cycle 0 → strobes in cycle 1 → ack and rdata in cycle 2.
- Miss/write latency: ack in the cycle after the edge where Stall is first sampled low.
- Requesters drop the request in the cycle after ack. A request still high in IDLE is treated as new.
- Back-to-back from one port: minimum 3 cycles per hit transaction (IDLE, ISSUE, RESP).
- A request arriving on the non-owner port during ISSUE/WAIT/RESP waits; it is granted in the next IDLE under round-robin.
- Request withdrawn after grant: transaction still completes and acks.

## Test plan
- Reset then idle: all outputs 0, strobes never assert for 10 cycles.
- p1_wr addr 0x004 data AABBCCDD, Stall high 4 cycles → MemWrite held 5 cycles with stable address/data, p1_ack pulse once, stall_cnt = 1, p1_rdata stays 0.
- p0_rd addr 0x004, Stall high 3 cycles, DataOut = AABBCCDD → p0_rdata = AABBCCDD at ack; then repeat with Stall low → ack 2 cycles after request, hit_cnt = 1.
- p0_rd and p1_rd raised same cycle, each held after ack for 3 rounds → grants alternate 0,1,0,1,0,1; no port granted twice in a row under contention.
- p1 asserting rd and wr together (addr 0x081, data FFFF0000) → only MemWrite driven, data FFFF0000.
- rst_n pulsed low while in WAIT → strobes drop asynchronously, no ack, counters 0; next request completes normally.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Purpose: shares one write-through data cache between instruction fetch (port 0) and load/store (port 1).
// Latency: a hit acks 2 cycles after the request; a miss or write acks the cycle after Stall is first seen low.
// Backpressure: requests are levels held until ack; Stall holds the owner on the cache, the other port waits.
// Ports: pN_rd/pN_wr/pN_addr/pN_wdata are requests in; pN_ack/pN_rdata are responses out.
//        MemRead/MemWrite/WordAddress/DataIn go to the cache; DataOut/Stall come from it.
//        hit_cnt/stall_cnt are saturating counts of completed transactions without/with Stall.
module cache_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_rd,
  input  logic              p0_wr,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_rd,
  input  logic              p1_wr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] WordAddress,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              Stall,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_is_wr;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_ack0;
  logic              r_ack1;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [CNT_W-1:0]  r_hit;
  logic [CNT_W-1:0]  r_stall;

  logic              w_req0;
  logic              w_req1;
  logic              w_grant;
  logic              w_g_wr;
  logic [ADDR_W-1:0] w_g_addr;
  logic [DATA_W-1:0] w_g_wdata;

  assign w_req0 = p0_rd | p0_wr;
  assign w_req1 = p1_rd | p1_wr;
  // Under contention the port not served last wins; otherwise the lone requester.
  assign w_grant   = (w_req0 && w_req1) ? ~r_last : w_req1;
  // Write wins over read when a port raises both.
  assign w_g_wr    = w_grant ? p1_wr    : p0_wr;
  assign w_g_addr  = w_grant ? p1_addr  : p0_addr;
  assign w_g_wdata = w_grant ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_is_wr     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_hit       <= '0;
      r_stall     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req0 || w_req1) begin
            // Request is latched here; requester inputs are not looked at again.
            r_owner     <= w_grant;
            r_is_wr     <= w_g_wr;
            r_mem_write <= w_g_wr;
            r_mem_read  <= ~w_g_wr;
            r_addr      <= w_g_addr;
            r_wdata     <= w_g_wdata;
            r_state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (!Stall) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (!r_is_wr) begin
              if (r_owner) r_rdata1 <= DataOut;
              else         r_rdata0 <= DataOut;
            end
            // Completion straight out of ISSUE never saw Stall, so it is a hit.
            if (r_state == ISSUE) begin
              if (r_hit != '1) r_hit <= r_hit + 1'b1;
            end else begin
              if (r_stall != '1) r_stall <= r_stall + 1'b1;
            end
            r_ack0  <= ~r_owner;
            r_ack1  <= r_owner;
            r_state <= RESP;
          end else begin
            r_state <= WAIT;
          end
        end
        RESP: begin
          // Strobes stay low this cycle so the cache sees a fresh request edge next time.
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemRead     = r_mem_read;
  assign MemWrite    = r_mem_write;
  assign WordAddress = r_addr;
  assign DataIn      = r_wdata;
  assign p0_ack      = r_ack0;
  assign p1_ack      = r_ack1;
  assign p0_rdata    = r_rdata0;
  assign p1_rdata    = r_rdata1;
  assign hit_cnt     = r_hit;
  assign stall_cnt   = r_stall;

endmodule
